// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
// State encoding doubles as the occupancy count.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_hold_reg.sv
// Single payload register with async reset and synchronous clear to BUBBLE.
// Clear dominates load.
module pipe_hold_reg #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o <= BUBBLE;
        end else if (clear_i) begin
            q_o <= BUBBLE;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// up_ready_o is decoded from the state register only, never from dn_ready_i.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_NOP),
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             up_ready_o,
    output logic             dn_valid_o,
    output logic [WIDTH-1:0] dn_data_o,
    input  logic             dn_ready_i,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             drain;
    logic             main_load;
    logic             main_clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             skid_load;
    logic             skid_clr;
    logic [WIDTH-1:0] skid_q;

    assign up_ready_o  = (state != ST_FULL);
    assign dn_valid_o  = (state != ST_EMPTY);
    assign occupancy_o = state;
    assign dn_data_o   = main_q;

    assign accept = up_valid_i & up_ready_o;
    assign drain  = dn_valid_o & dn_ready_i;

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_d    = up_data_i;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush_i) begin
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_HALF;
                        main_load = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        skid_load = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_nxt = ST_HALF;
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating count of downstream stall cycles; flush does not clear it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (dn_valid_o && !dn_ready_i && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    pipe_hold_reg #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .clear_i (main_clr),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_hold_reg #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .d_i     (up_data_i),
        .q_o     (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic
// checked against a queue-based FIFO model.
module tb_pipe_stage_skid;

    localparam int unsigned      WIDTH  = 32;
    localparam int unsigned      CNT_W  = 4;
    localparam logic [WIDTH-1:0] BUBBLE = 32'h0000_0013;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             up_ready;
    logic             dn_valid;
    logic [WIDTH-1:0] dn_data;
    logic             dn_ready;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq[$];
    int               mcnt = 0;
    int               drained = 0;

    pipe_stage_skid #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .up_valid_i  (up_valid),
        .up_data_i   (up_data),
        .up_ready_o  (up_ready),
        .dn_valid_o  (dn_valid),
        .dn_data_o   (dn_data),
        .dn_ready_i  (dn_ready),
        .occupancy_o (occupancy),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_head();
        return (mq.size() > 0) ? mq[0] : BUBBLE;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ":dn_valid"}, 32'(dn_valid), 32'(mq.size() > 0));
        chk({tag, ":dn_data"}, dn_data, model_head());
        chk({tag, ":up_ready"}, 32'(up_ready), 32'(mq.size() < 2));
        chk({tag, ":occupancy"}, 32'(occupancy), 32'(mq.size()));
        chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(mcnt));
    endtask

    // Called just after a falling edge: drive, clock, update model, check.
    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic r, input logic f, input string tag);
        bit acc;
        bit drn;
        up_valid = v;
        up_data  = d;
        dn_ready = r;
        flush    = f;
        #1;
        chk({tag, ":ready_comb"}, 32'(up_ready), 32'(mq.size() < 2));
        acc = v && (mq.size() < 2);
        drn = r && (mq.size() > 0);
        if (mq.size() > 0 && !r && mcnt < (1 << CNT_W) - 1) mcnt++;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (drn) begin
                void'(mq.pop_front());
                drained++;
            end
            if (acc) mq.push_back(d);
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b1;
        up_data  = 32'hFFFF_FFFF;
        dn_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model("reset");
        chk("reset:data", dn_data, BUBBLE);
        up_valid = 1'b0;
        rst = 1'b1;

        // Streaming with downstream always ready.
        cycle(1, 32'h11, 1, 0, "s1a");
        chk("s1:first", dn_data, 32'h11);
        cycle(1, 32'h22, 1, 0, "s1b");
        chk("s1:second", dn_data, 32'h22);
        cycle(1, 32'h33, 1, 0, "s1c");
        chk("s1:third", dn_data, 32'h33);
        chk("s1:occ", 32'(occupancy), 32'd1);
        cycle(0, 32'h0, 1, 0, "s1d");

        // Downstream stall fills the skid; release drains in order.
        cycle(1, 32'hA1, 0, 0, "s2a");
        chk("s2:occ1", 32'(occupancy), 32'd1);
        cycle(1, 32'hA2, 0, 0, "s2b");
        chk("s2:occ2", 32'(occupancy), 32'd2);
        chk("s2:notready", 32'(up_ready), 32'd0);
        cycle(1, 32'hA3, 0, 0, "s2c");
        chk("s2:held", dn_data, 32'hA1);
        cycle(1, 32'hA3, 1, 0, "s2d");
        chk("s2:out2", dn_data, 32'hA2);
        cycle(1, 32'hA3, 1, 0, "s2e");
        chk("s2:out3", dn_data, 32'hA3);
        cycle(0, 32'h0, 1, 0, "s2f");

        // Flush while full, with a competing push.
        cycle(1, 32'hB1, 0, 0, "s3a");
        cycle(1, 32'hB2, 0, 0, "s3b");
        chk("s3:full", 32'(occupancy), 32'd2);
        cycle(1, 32'hB3, 0, 1, "s3c");
        chk("s3:valid", 32'(dn_valid), 32'd0);
        chk("s3:data", dn_data, BUBBLE);
        chk("s3:occ", 32'(occupancy), 32'd0);
        chk("s3:ready", 32'(up_ready), 32'd1);
        cycle(0, 32'h0, 1, 0, "s3d");
        chk("s3:nob3", dn_data, BUBBLE);

        // Async reset mid-cycle while HALF.
        cycle(1, 32'hC1, 0, 0, "s4a");
        up_valid = 1'b1;
        up_data  = 32'hC2;
        #2 rst = 1'b0;
        #1;
        chk("s4:valid", 32'(dn_valid), 32'd0);
        chk("s4:data", dn_data, BUBBLE);
        chk("s4:ready", 32'(up_ready), 32'd1);
        chk("s4:cnt", 32'(stall_cnt), 32'd0);
        mq.delete();
        mcnt = 0;
        @(negedge clk);
        check_model("s4:nocapture");
        rst = 1'b1;

        // Stall counter saturation at 2^CNT_W-1.
        cycle(1, 32'hD1, 1, 0, "s5a");
        cycle(1, 32'hD2, 1, 0, "s5b");
        chk("s5:nocount", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 20; i++) cycle(0, 32'h0, 0, 0, "s5hold");
        chk("s5:sat", 32'(stall_cnt), 32'd15);
        cycle(0, 32'h0, 1, 0, "s5c");
        chk("s5:after", 32'(stall_cnt), 32'd15);

        // Random traffic against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                  ($urandom % 64) == 0, "rnd");
        end
        chk("rnd:progress", 32'(drained > 3000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
